// File: rtl/loas_candidate_arbiter.sv
`timescale 1ns/1ps
// LOAS candidate arbiter: grants one of NUM_REQ candidate producers per cycle into a one-entry
// output register feeding the candidate FIFO. Define SCORE_PRIO_EN for score priority with aging.
module loas_candidate_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int REQ_W       = 2,
    parameter int NEURON_ID_W = 4,
    parameter int COL_ID_W    = 4,
    parameter int SCORE_W     = 4,
    parameter int AGE_W       = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*NEURON_ID_W-1:0] req_neuron,
    input  logic [NUM_REQ*COL_ID_W-1:0]    req_col,
    input  logic [NUM_REQ*SCORE_W-1:0]     req_score,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NEURON_ID_W-1:0]         out_neuron,
    output logic [COL_ID_W-1:0]            out_col,
    output logic [SCORE_W-1:0]             out_score,
    output logic [REQ_W-1:0]               out_src,
    output logic [15:0]                    grant_cnt
);

    if (NUM_REQ < 2 || REQ_W != $clog2(NUM_REQ) || AGE_W < 1) begin : g_param_check
        $error("loas_candidate_arbiter: inconsistent parameters");
    end

    // Wrapping index helper: (base + offset) mod NUM_REQ, offset < NUM_REQ.
    function automatic logic [REQ_W-1:0] rr_index(input logic [REQ_W-1:0] base, input int offset);
        int sum;
        sum = int'(base) + offset;
        return (sum >= NUM_REQ) ? REQ_W'(sum - NUM_REQ) : REQ_W'(sum);
    endfunction

    logic [NEURON_ID_W-1:0] neuron_s [NUM_REQ];
    logic [COL_ID_W-1:0]    col_s    [NUM_REQ];
    logic [SCORE_W-1:0]     score_s  [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign neuron_s[gi] = req_neuron[gi*NEURON_ID_W +: NEURON_ID_W];
        assign col_s[gi]    = req_col[gi*COL_ID_W +: COL_ID_W];
        assign score_s[gi]  = req_score[gi*SCORE_W +: SCORE_W];
    end

    logic                   out_valid_q, out_valid_d;
    logic [NEURON_ID_W-1:0] neuron_q, neuron_d;
    logic [COL_ID_W-1:0]    col_q, col_d;
    logic [SCORE_W-1:0]     score_q, score_d;
    logic [REQ_W-1:0]       src_q, src_d;
    logic [REQ_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [15:0]            cnt_q, cnt_d;

    logic                   load_en_s;
    logic                   transfer_s;
    logic                   grant_any_s;
    logic [REQ_W-1:0]       grant_idx_s;
    logic [REQ_W-1:0]       scan_idx_s;
    logic                   take_s;

`ifdef SCORE_PRIO_EN
    localparam logic [AGE_W-1:0] AGE_LIMIT = {AGE_W{1'b1}};

    logic [AGE_W-1:0]   age_q [NUM_REQ];
    logic [AGE_W-1:0]   age_d [NUM_REQ];
    logic [SCORE_W-1:0] best_score_s;
    logic               aged_any_s;
    logic [REQ_W-1:0]   aged_idx_s;
    logic               take_aged_s;
`endif

    assign load_en_s  = !flush && (!out_valid_q || out_ready);
    assign transfer_s = load_en_s && grant_any_s;

    for (genvar gr = 0; gr < NUM_REQ; gr++) begin : g_ready
        assign req_ready[gr] = transfer_s && (grant_idx_s == REQ_W'(gr));
    end

    // Winner selection: scan requesters in round-robin order starting at rr_ptr.
    always_comb begin
        grant_any_s = 1'b0;
        grant_idx_s = {REQ_W{1'b0}};
        scan_idx_s  = {REQ_W{1'b0}};
        take_s      = 1'b0;
`ifdef SCORE_PRIO_EN
        best_score_s = {SCORE_W{1'b0}};
        aged_any_s   = 1'b0;
        aged_idx_s   = {REQ_W{1'b0}};
        take_aged_s  = 1'b0;
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx_s = rr_index(rr_ptr_q, k);
`ifdef SCORE_PRIO_EN
            // Strict '>' keeps the earliest round-robin position on score ties.
            take_aged_s  = req_valid[scan_idx_s] && (age_q[scan_idx_s] == AGE_LIMIT) && !aged_any_s;
            aged_idx_s   = take_aged_s ? scan_idx_s : aged_idx_s;
            aged_any_s   = aged_any_s | take_aged_s;
            take_s       = req_valid[scan_idx_s] && (!grant_any_s || (score_s[scan_idx_s] > best_score_s));
            best_score_s = take_s ? score_s[scan_idx_s] : best_score_s;
`else
            take_s       = req_valid[scan_idx_s] && !grant_any_s;
`endif
            grant_idx_s  = take_s ? scan_idx_s : grant_idx_s;
            grant_any_s  = grant_any_s | take_s;
        end
`ifdef SCORE_PRIO_EN
        grant_idx_s = aged_any_s ? aged_idx_s : grant_idx_s;
`endif
    end

    // Output register, round-robin pointer and grant counter next state; flush dominates.
    always_comb begin
        out_valid_d = out_valid_q;
        neuron_d    = neuron_q;
        col_d       = col_q;
        score_d     = score_q;
        src_d       = src_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        if (flush) begin
            out_valid_d = 1'b0;
            rr_ptr_d    = {REQ_W{1'b0}};
        end else if (transfer_s) begin
            out_valid_d = 1'b1;
            neuron_d    = neuron_s[grant_idx_s];
            col_d       = col_s[grant_idx_s];
            score_d     = score_s[grant_idx_s];
            src_d       = grant_idx_s;
            rr_ptr_d    = rr_index(grant_idx_s, 1);
            cnt_d       = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            neuron_q    <= {NEURON_ID_W{1'b0}};
            col_q       <= {COL_ID_W{1'b0}};
            score_q     <= {SCORE_W{1'b0}};
            src_q       <= {REQ_W{1'b0}};
            rr_ptr_q    <= {REQ_W{1'b0}};
            cnt_q       <= 16'h0000;
        end else begin
            out_valid_q <= out_valid_d;
            neuron_q    <= neuron_d;
            col_q       <= col_d;
            score_q     <= score_d;
            src_q       <= src_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
        end
    end

`ifdef SCORE_PRIO_EN
    // Starvation age: counts cycles a requester waits, cleared when it is taken or withdraws.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            age_d[i] = age_q[i];
            if (flush) begin
                age_d[i] = {AGE_W{1'b0}};
            end else if (!req_valid[i] || req_ready[i]) begin
                age_d[i] = {AGE_W{1'b0}};
            end else if (age_q[i] != AGE_LIMIT) begin
                age_d[i] = age_q[i] + {{(AGE_W-1){1'b0}}, 1'b1};
            end else begin
                age_d[i] = age_q[i];
            end
        end
    end

    // Age counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                age_q[i] <= {AGE_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end
`endif

    assign out_valid  = out_valid_q;
    assign out_neuron = neuron_q;
    assign out_col    = col_q;
    assign out_score  = score_q;
    assign out_src    = src_q;
    assign grant_cnt  = cnt_q;

endmodule

// File: tb/tb_loas_candidate_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for loas_candidate_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the arbitration rules.
module tb_loas_candidate_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_neuron;
    logic [15:0] req_col;
    logic [15:0] req_score;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_neuron;
    logic [3:0]  out_col;
    logic [3:0]  out_score;
    logic [1:0]  out_src;
    logic [15:0] grant_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    // Behavioural model state
    int m_valid, m_neu, m_col, m_sco, m_src, m_rr, m_cnt;
    int m_age [4];

    always #5 clk = ~clk;

    loas_candidate_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_neuron (req_neuron),
        .req_col    (req_col),
        .req_score  (req_score),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_neuron (out_neuron),
        .out_col    (out_col),
        .out_score  (out_score),
        .out_src    (out_src),
        .grant_cnt  (grant_cnt)
    );

    function automatic int fld(input logic [15:0] v, input int i);
        return int'(v[i*4 +: 4]);
    endfunction

    task automatic set_req(input int i, input bit v, input int n, input int c, input int s);
        req_valid[i]        = v;
        req_neuron[i*4 +: 4] = 4'(n);
        req_col[i*4 +: 4]    = 4'(c);
        req_score[i*4 +: 4]  = 4'(s);
    endtask

    task automatic model_reset();
        m_valid = 0; m_neu = 0; m_col = 0; m_sco = 0; m_src = 0; m_rr = 0; m_cnt = 0;
        for (int i = 0; i < 4; i++) m_age[i] = 0;
    endtask

    // Requester the rules would select this cycle, or -1.
    function automatic int pick();
        int best;
        best = -1;
`ifdef SCORE_PRIO_EN
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (m_rr + k) % 4;
            if (req_valid[idx] && m_age[idx] == 15) return idx;
        end
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (m_rr + k) % 4;
            if (req_valid[idx] && (best < 0 || fld(req_score, idx) > fld(req_score, best))) best = idx;
        end
`else
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (m_rr + k) % 4;
            if (req_valid[idx] && best < 0) best = idx;
        end
`endif
        return best;
    endfunction

    function automatic logic [3:0] exp_ready();
        int g;
        g = pick();
        if (!flush && (m_valid == 0 || out_ready) && g >= 0) return 4'b0001 << g;
        return 4'b0000;
    endfunction

    function automatic logic [13:0] exp_pack();
        return {4'(m_neu), 4'(m_col), 4'(m_sco), 2'(m_src)};
    endfunction

    // Apply one clock of the model, then move to just after the DUT's edge.
    task automatic advance();
        int  g;
        bit  le;
        g  = pick();
        le = !flush && (m_valid == 0 || out_ready);
        for (int i = 0; i < 4; i++) begin
            if (flush || !req_valid[i] || (le && g == i)) m_age[i] = 0;
            else if (m_age[i] < 15) m_age[i]++;
        end
        if (flush) begin
            m_valid = 0;
            m_rr    = 0;
        end else if (le && g >= 0) begin
            m_valid = 1;
            m_neu   = fld(req_neuron, g);
            m_col   = fld(req_col, g);
            m_sco   = fld(req_score, g);
            m_src   = g;
            m_rr    = (g + 1) % 4;
            if (m_cnt < 65535) m_cnt++;
        end else if (m_valid != 0 && out_ready) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        req_valid = 4'h0; req_neuron = 16'h0; req_col = 16'h0; req_score = 16'h0;
        model_reset();
        @(posedge clk); #1;
        tests_run++;
        if (out_valid !== 1'b0 || req_ready !== 4'h0 || grant_cnt !== 16'h0 || out_src !== 2'd0 ||
            {out_neuron, out_col, out_score} !== 12'h000) begin
            tests_failed++;
            $display("FAIL reset_state: got valid=%b ready=%b cnt=%0d src=%0d data=%h, expected all zero",
                     out_valid, req_ready, grant_cnt, out_src, {out_neuron, out_col, out_score});
        end
        rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            tests_run++;
            if (out_valid !== 1'b0 || req_ready !== 4'h0) begin
                tests_failed++;
                $display("FAIL reset_idle: got valid=%b ready=%b, expected 0/0", out_valid, req_ready);
            end
            advance();
        end
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
        out_ready = 1'b1;
        flush = 1'b0;
        for (int k = 0; k < 5; k++) begin
            logic [3:0] exp_c;
            exp_c = 4'b0001 << (k % 4);
            #1;
            tests_run++;
            if (req_ready !== exp_c || req_ready !== exp_ready()) begin
                tests_failed++;
                $display("FAIL rr_ready[%0d]: got %b expected %b", k, req_ready, exp_c);
            end
            advance();
            tests_run++;
            if (out_valid !== 1'b1 || out_src !== 2'(k % 4) || out_neuron !== 4'(fld(req_neuron, k % 4))) begin
                tests_failed++;
                $display("FAIL rr_src[%0d]: got valid=%b src=%0d neu=%0d expected 1/%0d/%0d",
                         k, out_valid, out_src, out_neuron, k % 4, fld(req_neuron, k % 4));
            end
        end
        tests_run++;
        if (grant_cnt !== 16'd5) begin
            tests_failed++;
            $display("FAIL rr_count: got %0d expected 5", grant_cnt);
        end
        req_valid = 4'h0;
        #1;
        advance();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rr_drain: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        req_valid = 4'h0;
        set_req(1, 1'b1, 5, 9, 3);
        out_ready = 1'b0;
        #1;
        tests_run++;
        if (req_ready !== 4'b0010) begin
            tests_failed++;
            $display("FAIL bp_load: got ready=%b expected 0010", req_ready);
        end
        advance();
        req_valid[1] = 1'b0;
        set_req(0, 1'b1, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
        set_req(2, 1'b1, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
        for (int k = 0; k < 3; k++) begin
            #1;
            tests_run++;
            if (req_ready !== 4'h0 || out_valid !== 1'b1 ||
                {out_neuron, out_col, out_score, out_src} !== {4'd5, 4'd9, 4'd3, 2'd1}) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: got ready=%b valid=%b n=%0d c=%0d s=%0d src=%0d expected 0000/1/5/9/3/1",
                         k, req_ready, out_valid, out_neuron, out_col, out_score, out_src);
            end
            advance();
        end
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (req_ready !== 4'b0100 || req_ready !== exp_ready()) begin
            tests_failed++;
            $display("FAIL bp_release: got ready=%b expected 0100", req_ready);
        end
        advance();
        req_valid[2] = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_src !== 2'd2) begin
            tests_failed++;
            $display("FAIL bp_next: got valid=%b src=%0d expected 1/2", out_valid, out_src);
        end
    endtask

    task automatic test_flush();
        req_valid = 4'h0;
        set_req(2, 1'b1, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
        out_ready = 1'($urandom_range(0, 1));
        flush = 1'b1;
        #1;
        tests_run++;
        if (req_ready !== 4'h0 || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_ready: got ready=%b valid=%b expected 0000/1", req_ready, out_valid);
        end
        advance();
        flush = 1'b0;
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || req_ready !== 4'b0100) begin
            tests_failed++;
            $display("FAIL flush_after: got valid=%b ready=%b expected 0/0100", out_valid, req_ready);
        end
        advance();
        req_valid = 4'h0;
        tests_run++;
        if (out_valid !== 1'b1 || out_src !== 2'd2) begin
            tests_failed++;
            $display("FAIL flush_regrant: got valid=%b src=%0d expected 1/2", out_valid, out_src);
        end
        // Pointer sits at 3 now; a flush must bring it back to 0.
        flush = 1'b1;
        #1;
        advance();
        flush = 1'b0;
        set_req(0, 1'b1, $urandom_range(0, 15), $urandom_range(0, 15), 1);
        set_req(3, 1'b1, $urandom_range(0, 15), $urandom_range(0, 15), 1);
        #1;
        tests_run++;
        if (req_ready !== 4'b0001 || req_ready !== exp_ready()) begin
            tests_failed++;
            $display("FAIL flush_ptr: got ready=%b expected 0001", req_ready);
        end
        advance();
        req_valid = 4'h0;
    endtask

    task automatic test_score_prio();
        req_valid = 4'h0;
        set_req(0, 1'b1, $urandom_range(0, 15), $urandom_range(0, 15), 2);
        set_req(3, 1'b1, $urandom_range(0, 15), $urandom_range(0, 15), 7);
        out_ready = 1'b1;
        flush = 1'b1;
        #1;
        advance();
        flush = 1'b0;
        for (int k = 0; k < 40; k++) begin
            int exp_src;
`ifdef SCORE_PRIO_EN
            exp_src = ((k % 16) == 15) ? 0 : 3;
`else
            exp_src = ((k % 2) == 0) ? 0 : 3;
`endif
            #1;
            tests_run++;
            if (req_ready !== exp_ready()) begin
                tests_failed++;
                $display("FAIL prio_ready[%0d]: got %b expected %b", k, req_ready, exp_ready());
            end
            advance();
            tests_run++;
            if (out_valid !== 1'b1 || out_src !== 2'(exp_src)) begin
                tests_failed++;
                $display("FAIL prio_src[%0d]: got valid=%b src=%0d expected 1/%0d", k, out_valid, out_src, exp_src);
            end
        end
        req_valid = 4'h0;
    endtask

    task automatic test_random();
        logic [3:0] pend;
        logic [3:0] er;
        pend = 4'h0;
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i]) set_req(i, $urandom_range(0, 99) < 55, $urandom_range(0, 15),
                                      $urandom_range(0, 15), $urandom_range(0, 15));
            end
            out_ready = $urandom_range(0, 99) < 70;
            flush     = $urandom_range(0, 99) < 4;
            #1;
            er = exp_ready();
            tests_run++;
            if (req_ready !== er) begin
                tests_failed++;
                $display("FAIL rand_ready[%0d]: got %b expected %b", k, req_ready, er);
            end
            tests_run++;
            if (out_valid !== 1'(m_valid) || grant_cnt !== 16'(m_cnt) ||
                (m_valid != 0 && {out_neuron, out_col, out_score, out_src} !== exp_pack())) begin
                tests_failed++;
                $display("FAIL rand_out[%0d]: got valid=%b cnt=%0d data=%h expected %0d/%0d/%h",
                         k, out_valid, grant_cnt, {out_neuron, out_col, out_score, out_src}, m_valid, m_cnt, exp_pack());
            end
            pend = req_valid & ~er;
            advance();
        end
        flush = 1'b0;
        req_valid = 4'h0;
    endtask

    task automatic test_async_reset();
        req_valid = 4'h0;
        flush = 1'b0;
        out_ready = 1'b1;
        #1;
        advance();
        set_req(1, 1'b1, $urandom_range(1, 15), $urandom_range(0, 15), $urandom_range(0, 15));
        out_ready = 1'b0;
        #1;
        advance();
        req_valid = 4'h0;
        tests_run++;
        if (out_valid !== 1'b1 || out_src !== 2'd1) begin
            tests_failed++;
            $display("FAIL areset_pre: got valid=%b src=%0d expected 1/1", out_valid, out_src);
        end
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || grant_cnt !== 16'h0 || out_src !== 2'd0 || out_neuron !== 4'd0) begin
            tests_failed++;
            $display("FAIL areset_now: got valid=%b cnt=%0d src=%0d neu=%0d expected 0/0/0/0",
                     out_valid, grant_cnt, out_src, out_neuron);
        end
        model_reset();
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
        out_ready = 1'b1;
        flush = 1'b0;
        #1;
        for (int k = 0; k < 65534; k++) advance();
        tests_run++;
        if (grant_cnt !== 16'hFFFE) begin
            tests_failed++;
            $display("FAIL sat_near: got %h expected FFFE", grant_cnt);
        end
        advance();
        tests_run++;
        if (grant_cnt !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL sat_hit: got %h expected FFFF", grant_cnt);
        end
        for (int k = 0; k < 5; k++) advance();
        tests_run++;
        if (grant_cnt !== 16'hFFFF || grant_cnt !== 16'(m_cnt) || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL sat_hold: got cnt=%h valid=%b expected FFFF/1", grant_cnt, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_backpressure();
        test_flush();
        test_score_prio();
        test_random();
        test_async_reset();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
